// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state encoding and the iteration-counter width helper.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    localparam int DEF_WIDTH = 32;

    // Bits needed to count 0..w-1 (at least one bit).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One result bit per RUN cycle (shift-add multiply, restoring divide) on
// unsigned magnitudes; signs are applied in the single FIX cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_rs,
    input  logic [WIDTH-1:0] i_rt,
    input  logic             i_mthi,
    input  logic             i_mtlo,
    input  logic             i_hilo_sel,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_result
);

    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Two's-complement absolute value / conditional negate.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    // Datapath registers (no reset: always loaded at start before use).
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               div_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               dz_q;

    op_e  op_in;
    logic in_signed, in_div, rs_neg, rt_neg, start_acc;

    assign op_in     = op_e'(i_op);
    assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign in_div    = (op_in == OP_DIV)  || (op_in == OP_DIVU);
    assign rs_neg    = in_signed & i_rs[WIDTH-1];
    assign rt_neg    = in_signed & i_rt[WIDTH-1];
    assign start_acc = (state_q == ST_IDLE) && i_start;

    // One iteration step: multiply adds the multiplicand on the LSB then
    // shifts right; divide shifts the remainder left and trial-subtracts.
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_step;

    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge    = div_trial >= {1'b0, opnd_q};
    assign div_diff  = div_trial - {1'b0, opnd_q};
    assign acc_step  = div_q
        ? {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge}
        : {mul_sum, acc_q[WIDTH-1:1]};

    // Sign fix-up; a zero divisor forces an all-ones quotient, while the
    // remainder path naturally reconstructs the original dividend.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_fix = cond_neg2(acc_q, neg_res_q);
    assign quo_fix  = dz_q ? '1 : cond_neg(acc_q[WIDTH-1:0], neg_res_q);
    assign rem_fix  = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);

    // State register, iteration counter and done pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ST_FIX);
            if (start_acc)
                cnt_q <= '0;
            else if (state_q == ST_RUN)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from registered state.
    always_comb begin
        o_busy = (state_q != ST_IDLE);
        o_done = done_q;
    end

    // Operand capture at start, one iteration per RUN cycle.
    always_ff @(posedge i_clk) begin
        if (start_acc) begin
            div_q     <= in_div;
            neg_res_q <= rs_neg ^ rt_neg;
            neg_rem_q <= rs_neg;
            dz_q      <= in_div && (i_rt == '0);
            opnd_q    <= in_div ? cond_neg(i_rt, rt_neg) : cond_neg(i_rs, rs_neg);
            acc_q     <= {{WIDTH{1'b0}}, (in_div ? cond_neg(i_rs, rs_neg) : cond_neg(i_rt, rt_neg))};
        end else if (state_q == ST_RUN) begin
            acc_q <= acc_step;
        end
    end

    // HI/LO next value: result at end of FIX, else MTHI/MTLO in idle.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == ST_FIX) begin
            hi_d = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            lo_d = div_q ? quo_fix : prod_fix[WIDTH-1:0];
        end else if ((state_q == ST_IDLE) && !i_start) begin
            if (i_mthi) hi_d = i_rs;
            if (i_mtlo) lo_d = i_rs;
        end
    end

    // Architectural HI/LO registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign o_hi     = hi_q;
    assign o_lo     = lo_q;
    assign o_result = i_hilo_sel ? hi_q : lo_q;

endmodule
